// File: rtl/zvc_decompressor_pkg.sv
// Shared definitions for the zero-value compression/decompression path:
// lane counts, derived bus widths and lane-slice helpers for the packed buses.
package zvc_decompressor_pkg;

  localparam int unsigned LANES         = 128;
  localparam int unsigned WORD_WIDTH    = 8;
  localparam int unsigned PSUM_WIDTH    = 7;
  localparam int unsigned DIST_WIDTH    = 7;
  localparam int unsigned MAX_LIFM_RSIZ = 4;
  localparam int unsigned MTW           = DIST_WIDTH * MAX_LIFM_RSIZ;
  localparam int unsigned CNT_WIDTH     = 8;
  localparam int unsigned LIFM_BUS_W    = LANES * WORD_WIDTH;
  localparam int unsigned MT_BUS_W      = LANES * MTW;
  localparam int unsigned PSUM_BUS_W    = LANES * PSUM_WIDTH;

  function automatic logic [WORD_WIDTH-1:0] lifm_lane(input logic [LIFM_BUS_W-1:0] bus,
                                                      input logic [PSUM_WIDTH-1:0] idx);
    return bus[idx*WORD_WIDTH +: WORD_WIDTH];
  endfunction

  function automatic logic [MTW-1:0] mt_lane(input logic [MT_BUS_W-1:0] bus,
                                             input logic [PSUM_WIDTH-1:0] idx);
    return bus[idx*MTW +: MTW];
  endfunction

endpackage

// File: rtl/zvc_expand_gather128.sv
// Combinational gather: each output lane picks compressed lane psum[i] when
// keep[i] is set, otherwise drives zero.
module zvc_expand_gather128
  import zvc_decompressor_pkg::*;
(
  input  logic [PSUM_BUS_W-1:0] psum,
  input  logic [LANES-1:0]      keep,
  input  logic [LIFM_BUS_W-1:0] lifm_in,
  input  logic [MT_BUS_W-1:0]   mt_in,
  output logic [LIFM_BUS_W-1:0] lifm_out,
  output logic [MT_BUS_W-1:0]   mt_out
);

  // One 128:1 mux per lane, gated by the keep bit.
  always_comb begin
    lifm_out = '0;
    mt_out   = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (keep[i]) begin
        lifm_out[i*WORD_WIDTH +: WORD_WIDTH] = lifm_lane(lifm_in, psum[i*PSUM_WIDTH +: PSUM_WIDTH]);
        mt_out[i*MTW +: MTW]                 = mt_lane(mt_in, psum[i*PSUM_WIDTH +: PSUM_WIDTH]);
      end
    end
  end

endmodule

// File: rtl/zvc_decompressor.sv
// Zero-value decompressor: 2-stage valid/ready pipeline re-expanding a
// bubble-collapsed 128-lane line. Optional count check: ZVC_DECOMP_CNT_CHECK_EN.
module zvc_decompressor
  import zvc_decompressor_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES-1:0]      keep_mask,
  input  logic [CNT_WIDTH-1:0]  comp_cnt,
  input  logic [LIFM_BUS_W-1:0] lifm_comp,
  input  logic [MT_BUS_W-1:0]   mt_comp,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LIFM_BUS_W-1:0] lifm_line,
  output logic [MT_BUS_W-1:0]   mt_line,
  output logic                  cnt_err
);

  // Kogge-Stone inclusive scan of the keep bits, shifted by one lane to form
  // the exclusive prefix sum (log2(128) = 7 levels, no ripple chain).
  function automatic logic [PSUM_BUS_W-1:0] excl_psum(input logic [LANES-1:0] k);
    logic [CNT_WIDTH-1:0]  s [LANES];
    logic [CNT_WIDTH-1:0]  t [LANES];
    logic [PSUM_BUS_W-1:0] r;
    for (int unsigned i = 0; i < LANES; i++) s[i] = CNT_WIDTH'(k[i]);
    for (int unsigned d = 1; d < LANES; d = d * 2) begin
      t = s;
      for (int unsigned i = 0; i < LANES; i++) begin
        if (i >= d) s[i] = t[i] + t[i-d];
      end
    end
    r = '0;
    for (int unsigned i = 1; i < LANES; i++) r[i*PSUM_WIDTH +: PSUM_WIDTH] = s[i-1][PSUM_WIDTH-1:0];
    return r;
  endfunction

  logic                  advance;
  logic [PSUM_BUS_W-1:0] psum_in;
  logic                  s1_valid_q, s1_valid_d;
  logic [LANES-1:0]      s1_keep_q,  s1_keep_d;
  logic [LIFM_BUS_W-1:0] s1_lifm_q,  s1_lifm_d;
  logic [MT_BUS_W-1:0]   s1_mt_q,    s1_mt_d;
  logic [PSUM_BUS_W-1:0] s1_psum_q,  s1_psum_d;
  logic                  out_valid_q, out_valid_d;
  logic [LIFM_BUS_W-1:0] out_lifm_q,  out_lifm_d;
  logic [MT_BUS_W-1:0]   out_mt_q,    out_mt_d;
  logic [LIFM_BUS_W-1:0] gather_lifm;
  logic [MT_BUS_W-1:0]   gather_mt;

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance && !reset;
  assign psum_in   = excl_psum(keep_mask);
  assign out_valid = out_valid_q;
  assign lifm_line = out_lifm_q;
  assign mt_line   = out_mt_q;

  zvc_expand_gather128 u_gather (
    .psum     (s1_psum_q),
    .keep     (s1_keep_q),
    .lifm_in  (s1_lifm_q),
    .mt_in    (s1_mt_q),
    .lifm_out (gather_lifm),
    .mt_out   (gather_mt)
  );

  // Stall-all pipeline: both stages load together on advance, else hold.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_keep_d   = s1_keep_q;
    s1_lifm_d   = s1_lifm_q;
    s1_mt_d     = s1_mt_q;
    s1_psum_d   = s1_psum_q;
    out_valid_d = out_valid_q;
    out_lifm_d  = out_lifm_q;
    out_mt_d    = out_mt_q;
    if (advance) begin
      s1_valid_d  = in_valid;
      s1_keep_d   = keep_mask;
      s1_lifm_d   = lifm_comp;
      s1_mt_d     = mt_comp;
      s1_psum_d   = psum_in;
      out_valid_d = s1_valid_q;
      out_lifm_d  = gather_lifm;
      out_mt_d    = gather_mt;
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_keep_q   <= '0;
      s1_lifm_q   <= '0;
      s1_mt_q     <= '0;
      s1_psum_q   <= '0;
      out_valid_q <= 1'b0;
      out_lifm_q  <= '0;
      out_mt_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_keep_q   <= s1_keep_d;
      s1_lifm_q   <= s1_lifm_d;
      s1_mt_q     <= s1_mt_d;
      s1_psum_q   <= s1_psum_d;
      out_valid_q <= out_valid_d;
      out_lifm_q  <= out_lifm_d;
      out_mt_q    <= out_mt_d;
    end
  end

`ifdef ZVC_DECOMP_CNT_CHECK_EN
  logic [CNT_WIDTH-1:0] pop_in;
  logic [CNT_WIDTH-1:0] s1_cnt_q, s1_cnt_d;
  logic [CNT_WIDTH-1:0] s1_pop_q, s1_pop_d;
  logic                 cnt_err_q, cnt_err_d;

  // Total popcount reuses the last exclusive prefix plus the top keep bit.
  assign pop_in  = CNT_WIDTH'(psum_in[(LANES-1)*PSUM_WIDTH +: PSUM_WIDTH]) + CNT_WIDTH'(keep_mask[LANES-1]);
  assign cnt_err = cnt_err_q;

  // Capture count/popcount with S1; flag a mismatch as the line moves to S2.
  always_comb begin
    s1_cnt_d  = s1_cnt_q;
    s1_pop_d  = s1_pop_q;
    cnt_err_d = cnt_err_q;
    if (advance) begin
      s1_cnt_d = comp_cnt;
      s1_pop_d = pop_in;
      if (s1_valid_q && (s1_pop_q != s1_cnt_q)) cnt_err_d = 1'b1;
    end
  end

  // Count-check registers; the error flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_cnt_q  <= '0;
      s1_pop_q  <= '0;
      cnt_err_q <= 1'b0;
    end else begin
      s1_cnt_q  <= s1_cnt_d;
      s1_pop_q  <= s1_pop_d;
      cnt_err_q <= cnt_err_d;
    end
  end
`else
  logic unused_comp_cnt;
  assign unused_comp_cnt = |comp_cnt;
  assign cnt_err         = 1'b0;
`endif

endmodule

// File: tb/tb_zvc_decompressor.sv
// Self-checking bench for zvc_decompressor: table-driven lines plus
// hand-written multi-cycle sequences, with a scoreboard of expected lines.
module tb_zvc_decompressor;
  import zvc_decompressor_pkg::*;

  typedef struct {
    logic [LANES-1:0]      keep;
    logic [LIFM_BUS_W-1:0] lifm;
    logic [MT_BUS_W-1:0]   mt;
    logic [7:0]            cnt;
    logic [LIFM_BUS_W-1:0] exp_lifm;
    logic [MT_BUS_W-1:0]   exp_mt;
  } vec_t;

  logic                  clk = 1'b0;
  logic                  reset, in_valid, in_ready, out_valid, out_ready, cnt_err;
  logic [LANES-1:0]      keep_mask;
  logic [7:0]            comp_cnt;
  logic [LIFM_BUS_W-1:0] lifm_comp, lifm_line;
  logic [MT_BUS_W-1:0]   mt_comp, mt_line;

  zvc_decompressor dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .keep_mask(keep_mask), .comp_cnt(comp_cnt), .lifm_comp(lifm_comp), .mt_comp(mt_comp),
    .out_valid(out_valid), .out_ready(out_ready), .lifm_line(lifm_line), .mt_line(mt_line),
    .cnt_err(cnt_err)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t sb[$];
  vec_t cur;
  vec_t vecs[6];
  vec_t bp[5];
  logic mv1 = 1'b0, mv2 = 1'b0, merr = 1'b0, m1bad = 1'b0;
  logic last_acc;

  // Reference expansion: walk the kept lanes with a running source index.
  function automatic vec_t make_vec(input logic [LANES-1:0] k, input logic [LIFM_BUS_W-1:0] l,
                                    input logic [MT_BUS_W-1:0] m, input logic [7:0] c);
    vec_t v;
    int unsigned j = 0;
    v.keep = k; v.lifm = l; v.mt = m; v.cnt = c;
    v.exp_lifm = '0; v.exp_mt = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (k[i]) begin
        v.exp_lifm[i*WORD_WIDTH +: WORD_WIDTH] = l[j*WORD_WIDTH +: WORD_WIDTH];
        v.exp_mt[i*MTW +: MTW]                 = m[j*MTW +: MTW];
        j++;
      end
    end
    return v;
  endfunction

  function automatic vec_t rand_vec();
    logic [LANES-1:0]      k;
    logic [LIFM_BUS_W-1:0] l;
    logic [MT_BUS_W-1:0]   m;
    for (int i = 0; i < LANES/32; i++)      k[i*32 +: 32] = $urandom;
    for (int i = 0; i < LIFM_BUS_W/32; i++) l[i*32 +: 32] = $urandom;
    for (int i = 0; i < MT_BUS_W/32; i++)   m[i*32 +: 32] = $urandom;
    return make_vec(k, l, m, 8'($countones(k)));
  endfunction

  task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  task automatic check_line(input string nm, input logic [LIFM_BUS_W-1:0] al, input logic [LIFM_BUS_W-1:0] el,
                            input logic [MT_BUS_W-1:0] am, input logic [MT_BUS_W-1:0] em);
    n_checks++;
    if (al === el && am === em) n_pass++;
    else begin
      for (int i = 0; i < LANES; i++) begin
        if (al[i*WORD_WIDTH +: WORD_WIDTH] !== el[i*WORD_WIDTH +: WORD_WIDTH] ||
            am[i*MTW +: MTW] !== em[i*MTW +: MTW]) begin
          $display("FAIL %s lane %0d: lifm got %h want %h, mt got %h want %h", nm, i,
                   al[i*WORD_WIDTH +: WORD_WIDTH], el[i*WORD_WIDTH +: WORD_WIDTH],
                   am[i*MTW +: MTW], em[i*MTW +: MTW]);
          break;
        end
      end
    end
  endtask

  task automatic drive(input vec_t v, input logic vld);
    cur       = v;
    in_valid  = vld;
    keep_mask = v.keep;
    comp_cnt  = v.cnt;
    lifm_comp = v.lifm;
    mt_comp   = v.mt;
  endtask

  // One clock: check outputs against the valid/error model and scoreboard,
  // record acceptance, step the model, then move to just after the edge.
  task automatic cycle();
    logic adv;
    #2;
    adv = !mv2 || out_ready;
    check_val("in_ready", 32'(in_ready), 32'(adv && !reset));
    check_val("out_valid", 32'(out_valid), 32'(mv2));
    check_val("cnt_err", 32'(cnt_err), 32'(merr));
    if (mv2 && out_valid) begin
      if (sb.size() == 0) check_val("sb_nonempty", 32'(0), 32'(1));
      else begin
        check_line("payload", lifm_line, sb[0].exp_lifm, mt_line, sb[0].exp_mt);
        if (out_ready) void'(sb.pop_front());
      end
    end
    last_acc = in_valid && adv && !reset;
    if (last_acc) sb.push_back(cur);
    if (reset) begin
      mv1 = 1'b0; mv2 = 1'b0; merr = 1'b0; m1bad = 1'b0;
      sb.delete();
    end else if (adv) begin
`ifdef ZVC_DECOMP_CNT_CHECK_EN
      if (mv1 && m1bad) merr = 1'b1;
`endif
      mv2   = mv1;
      mv1   = in_valid;
      m1bad = (8'($countones(keep_mask)) != comp_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    check_val("drained", 32'(sb.size()), 32'(0));
  endtask

  initial begin
    logic [LANES-1:0]      k;
    logic [LIFM_BUS_W-1:0] l;
    logic [MT_BUS_W-1:0]   m;
    logic [5:0]            pat;
    int                    idx, waited;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    keep_mask = '0; comp_cnt = '0; lifm_comp = '0; mt_comp = '0;
    cur = make_vec('0, '0, '0, 8'd0);
    @(posedge clk); #1;

    // Identity and sparse-scatter reference lines, then random ones.
    for (int i = 0; i < LANES; i++) begin
      l[i*WORD_WIDTH +: WORD_WIDTH] = 8'(i);
      m[i*MTW +: MTW]               = MTW'(i + 1);
    end
    vecs[0] = make_vec('1, l, m, 8'd128);
    k = '0; k[3] = 1'b1; k[64] = 1'b1; k[127] = 1'b1;
    l = '1; m = '1;
    l[7:0] = 8'hA1; l[15:8] = 8'hB2; l[23:16] = 8'hC3;
    m[MTW-1:0] = 28'h0000011; m[2*MTW-1:MTW] = 28'h0000022; m[3*MTW-1:2*MTW] = 28'h0000033;
    vecs[1] = make_vec(k, l, m, 8'd3);
    for (int i = 2; i < 6; i++) vecs[i] = rand_vec();

    // Reset state.
    cycle();
    check_line("reset_payload", lifm_line, '0, mt_line, '0);
    check_val("reset_out_valid", 32'(out_valid), 32'(0));
    reset = 1'b0;

    // Table: back-to-back lines with out_ready held high.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i], 1'b1);
      cycle();
    end
    drain(4);

    // Sparse scatter checked directly against hand values.
    drive(vecs[1], 1'b1);
    cycle();
    in_valid = 1'b0;
    waited = 0;
    while (!out_valid && waited < 10) begin cycle(); waited++; end
    check_val("sparse_latency", 32'(waited), 32'(1));
    check_val("sparse_l3",   32'(lifm_line[3*8 +: 8]),   32'hA1);
    check_val("sparse_l64",  32'(lifm_line[64*8 +: 8]),  32'hB2);
    check_val("sparse_l127", 32'(lifm_line[127*8 +: 8]), 32'hC3);
    check_val("sparse_m64",  32'(mt_line[64*MTW +: MTW]), 32'h22);
    check_val("sparse_l4",   32'(lifm_line[4*8 +: 8]),   32'h0);
    drain(3);

    // Backpressure: out_ready low for cycles 3..6 while streaming 5 lines.
    for (int i = 0; i < 5; i++) bp[i] = rand_vec();
    idx = 0;
    for (int c = 0; c < 40 && idx < 5; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      drive(bp[idx], 1'b1);
      cycle();
      if (last_acc) idx++;
    end
    check_val("bp_all_accepted", 32'(idx), 32'(5));
    drain(6);

    // All-zero line, two bubbles, identity line.
    pat = '0;
    drive(make_vec('0, vecs[0].lifm, vecs[0].mt, 8'd0), 1'b1);
    cycle(); pat[0] = out_valid;
    in_valid = 1'b0;
    cycle(); pat[1] = out_valid;
    cycle(); pat[2] = out_valid;
    drive(vecs[0], 1'b1);
    cycle(); pat[3] = out_valid;
    in_valid = 1'b0;
    cycle(); pat[4] = out_valid;
    cycle(); pat[5] = out_valid;
    check_val("bubble_pattern", 32'(pat), 32'b010010);
    drain(2);

    // Reset while two lines are in flight.
    drive(vecs[2], 1'b1); cycle();
    drive(vecs[3], 1'b1); cycle();
    reset = 1'b1;
    drive(vecs[4], 1'b1); cycle();
    check_val("mid_reset_valid", 32'(out_valid), 32'(0));
    check_line("mid_reset_payload", lifm_line, '0, mt_line, '0);
    reset = 1'b0; in_valid = 1'b0;
    cycle();
    check_val("post_reset_no_valid", 32'(out_valid), 32'(0));
    drive(vecs[5], 1'b1); cycle();
    in_valid = 1'b0;
    check_val("post_reset_lat1", 32'(out_valid), 32'(0));
    cycle();
    check_val("post_reset_lat2", 32'(out_valid), 32'(1));
    drain(3);

    // Count mismatch: popcount 10 with comp_cnt 9, then three good lines.
    k = '0;
    for (int i = 0; i < 10; i++) k[i*7] = 1'b1;
    drive(make_vec(k, vecs[2].lifm, vecs[2].mt, 8'd9), 1'b1);
    cycle();
    for (int i = 2; i < 5; i++) begin drive(vecs[i], 1'b1); cycle(); end
    drain(4);
`ifdef ZVC_DECOMP_CNT_CHECK_EN
    check_val("cnt_err_sticky", 32'(cnt_err), 32'(1));
`else
    check_val("cnt_err_tied", 32'(cnt_err), 32'(0));
`endif
    reset = 1'b1; cycle();
    reset = 1'b0; cycle();
    check_val("cnt_err_cleared", 32'(cnt_err), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/zvc_decompressor.md
# zvc_decompressor

Zero-value decompressor: re-expands a bubble-collapsed 128-lane line (lowered IFM words plus mapping-table entries) to its original lane positions, inserting zeros wherever the keep mask is clear. It is the inverse of the zero-value compression path. It sits between the compressed-line buffer and the PE-array feed. It is a 2-stage valid/ready pipeline with throughput of one line per cycle.

## Interface
- WORD_WIDTH, 8, bits per lowered-IFM word
- PSUM_WIDTH, 7, exclusive prefix-sum width (lane index 0..127)
- DIST_WIDTH, 7, bits per mapping-table distance field
- MAX_LIFM_RSIZ, 4, distance fields per lane; MT lane width MTW = DIST_WIDTH*MAX_LIFM_RSIZ
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input line valid
- in_ready  out  1  block accepts input this cycle
- keep_mask  in  128  bit i = 1: original lane i was nonzero (kept)
- comp_cnt  in  8  number of valid compressed words, 0..128
- lifm_comp  in  128*WORD_WIDTH  compressed words, packed from lane 0 upward
- mt_comp  in  128*MTW  compressed MT entries, packed the same way
- out_valid  out  1  expanded line valid
- out_ready  in  1  downstream accepts
- lifm_line  out  128*WORD_WIDTH  expanded lowered-IFM line
- mt_line  out  128*MTW  expanded mapping table
- cnt_err  out  1  sticky count-mismatch flag (see Configuration)

## Operation
- Stage 1 (S1) registers keep_mask, lifm_comp and mt_comp. It also registers the exclusive prefix sum of keep_mask: psum[i] = popcount(keep_mask[i-1:0]), with psum[0] = 0, 7 bits wide.
- Stage 2 (S2) gathers from the S1 registers:
  - if keep[i] = 1: lifm_line lane i = lifm lane psum[i], and mt_line lane i = mt lane psum[i]
  - if keep[i] = 0: both lanes of i are zero
- Compressed lanes at index >= popcount(keep) are ignored. Their contents must not affect the output.
- Stall-all flow control:
  - advance = !out_valid || out_ready
  - in_ready = advance && !reset
- On advance:
  - S1 loads the input and sets s1_valid = in_valid.
  - S2 loads the gather result and sets out_valid = s1_valid.
- Without advance, both stages hold all registers, including payload.
- A transfer occurs when in_valid && in_ready. Payload registers may load unconditionally on advance. Output payload is only meaningful while out_valid = 1.
- keep_mask = all ones: output equals input (identity). keep_mask = 0: output is all zeros and the line still propagates with valid.

## Timing
- Latency: 2 cycles from accepted input to out_valid, with no backpressure.
- Throughput: 1 line/cycle while out_ready = 1.
- out_valid and payload stay stable while out_valid && !out_ready.
- Reset (synchronous, high):
  - s1_valid = 0, out_valid = 0, cnt_err = 0
  - all payload and psum registers = 0
  - in_ready = 0 while reset is high
- Reset asserted mid-stream: lines in flight are discarded. No output valid appears on the cycle after reset is released.
- Simultaneous out_ready deassert and in_valid: input is not accepted (in_ready = 0 that cycle).
- Bubble in the input (in_valid = 0 on an advance cycle): it propagates as out_valid = 0 two cycles later. No stale line is repeated.

## Configuration
- ZVC_DECOMP_CNT_CHECK_EN defined:
  - S1 also registers comp_cnt and the 8-bit popcount of keep_mask.
  - On an S1→S2 advance with s1_valid = 1 and popcount != comp_cnt, cnt_err sets on the next edge.
  - cnt_err stays set until reset. Data flow is unaffected.
- Not defined:
  - comp_cnt is unused.
  - cnt_err is tied to 0.
  - No popcount logic is synthesized.

## Structure
- Shared package:
  - LANES = 128
  - MTW derivation
  - psum and count widths
  - lane-slice helper functions for the packed WORD_WIDTH and MTW buses, shared with the compressor side
- One sub-module: zvc_expand_gather128. It is combinational: psum, keep, and the packed lifm/mt in; expanded lifm/mt out; one 128:1 mux per lane selected by psum[i], gated by keep[i].
- The prefix sum is computed in the top level with the same parallel-prefix structure as the compressor. It must not be a 128-deep ripple chain.

## Test plan
- Identity: keep = all ones, lifm_comp lane k = k, mt_comp lane k = k+1 → two cycles later lifm_line lane k = k, mt_line lane k = k+1, out_valid = 1 for exactly one cycle.
- Sparse scatter: keep bits set only at lanes 3, 64, 127; compressed lanes 0..2 = 0xA1, 0xB2, 0xC3; lanes 3..127 filled with 0xFF garbage → lane 3 = 0xA1, lane 64 = 0xB2, lane 127 = 0xC3, all other lanes 0 in both lifm and mt.
- Backpressure: stream 5 lines with random masks, out_ready low for cycles 3–6 → in_ready low during the stall, output held stable, all 5 lines emerge in order with none lost or duplicated; compare against a reference model.
- All-zero and bubbles: keep = 0 line, then in_valid low for 2 cycles, then an identity line → zero line with valid, 2 invalid cycles, then the identity line.
- Reset mid-stream: assert reset for 1 cycle while 2 lines are in flight → out_valid = 0, all outputs 0, in_ready = 0 during reset; the first post-reset line appears 2 cycles after acceptance.
- With ZVC_DECOMP_CNT_CHECK_EN: keep popcount 10, comp_cnt = 9 → cnt_err rises with that line's S2 load and stays high through 3 following correct lines until reset; line data is still correct.
